// File: rtl/bin_to_xs3_serial_if.sv
// rtl/bin_to_xs3_serial_if.sv - operand/result handshake bundle for the serial binary-to-decimal converter
interface bin_to_xs3_serial_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      bin;
  logic                  mode;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   digits;
  logic                  overflow;

  modport master (
    output in_valid, bin, mode, out_ready,
    input  in_ready, out_valid, digits, overflow
  );

  modport slave (
    input  in_valid, bin, mode, out_ready,
    output in_ready, out_valid, digits, overflow
  );
endinterface

// File: rtl/bin_to_xs3_serial.sv
// rtl/bin_to_xs3_serial.sv - one-bit-per-cycle double-dabble converter to packed BCD or excess-3
module bin_to_xs3_serial #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bin_to_xs3_serial_if.slave   bus
);
  localparam int ACC_W = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   digits_q, digits_d;
  logic [5:0]         cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic               sticky_q, sticky_d;
  logic               ovf_q, ovf_d;

  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_nxt;
  logic [ACC_W-1:0]   acc_xs3;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    acc_d    = acc_q;
    digits_d = digits_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    sticky_d = sticky_q;
    ovf_d    = ovf_q;

    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    acc_nxt = {acc_adj[ACC_W-2:0], shift_q[BIN_W-1]};
    // Final digits are all <= 9, so the excess-3 bias never wraps a nibble.
    acc_xs3 = acc_nxt;
    for (int i = 0; i < DIGITS; i++) begin
      acc_xs3[4*i +: 4] = acc_nxt[4*i +: 4] + 4'd3;
    end

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          shift_d  = bus.bin;
          mode_d   = bus.mode;
          acc_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = 6'(BIN_W);
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        acc_d    = acc_nxt;
        shift_d  = {shift_q[BIN_W-2:0], 1'b0};
        // Any bit leaving the top digit means the operand needs more digits.
        sticky_d = sticky_q | acc_adj[ACC_W-1];
        cnt_d    = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          digits_d = mode_q ? acc_xs3 : acc_nxt;
          ovf_d    = sticky_d;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      acc_q    <= '0;
      digits_q <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      acc_q    <= acc_d;
      digits_q <= digits_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && rst_n;
  assign bus.out_valid = (state_q == DONE);
  assign bus.digits    = digits_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_bin_to_xs3_serial.sv
// tb/tb_bin_to_xs3_serial.sv - directed and sweep checks for bin_to_xs3_serial (8b/3 digits and 8b/2 digits)
module tb_bin_to_xs3_serial;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  int   n_acc = 0;
  int   n_out = 0;

  always #5 clk = ~clk;

  bin_to_xs3_serial_if #(.BIN_W(8), .DIGITS(3)) ifa ();
  bin_to_xs3_serial_if #(.BIN_W(8), .DIGITS(2)) ifb ();

  bin_to_xs3_serial #(.BIN_W(8), .DIGITS(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  bin_to_xs3_serial #(.BIN_W(8), .DIGITS(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  always @(posedge clk) begin
    if (rst_n) begin
      if (ifa.in_valid && ifa.in_ready) n_acc <= n_acc + 1;
      if (ifa.out_valid && ifa.out_ready) n_out <= n_out + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] ref_a(input int v, input logic m);
    logic [11:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 3; i++) begin
      r[4*i +: 4] = 4'((t % 10) + (m ? 3 : 0));
      t = t / 10;
    end
    return r;
  endfunction

  task automatic accept_a(input string tag, input logic [7:0] b, input logic m);
    int n = 0;
    while (!ifa.in_ready && n < 50) begin step(); n++; end
    chk({tag, " in_ready"}, 32'(ifa.in_ready), 32'd1);
    ifa.in_valid = 1'b1;
    ifa.bin      = b;
    ifa.mode     = m;
    step();
    ifa.in_valid = 1'b0;
    ifa.bin      = ~b;
    ifa.mode     = ~m;
  endtask

  task automatic run_a(input string tag, input logic [7:0] b, input logic m,
                       input logic [11:0] ed, input logic eo);
    int n = 0;
    accept_a(tag, b, m);
    while (!ifa.out_valid && n < 50) begin step(); n++; end
    chk({tag, " latency"}, 32'(n), 32'd8);
    chk({tag, " digits"}, 32'(ifa.digits), 32'(ed));
    chk({tag, " ovf"}, 32'(ifa.overflow), 32'(eo));
    step();
    chk({tag, " in_ready after handoff"}, 32'(ifa.in_ready), 32'd1);
  endtask

  task automatic run_b(input string tag, input logic [7:0] b, input logic m,
                       input logic [7:0] ed, input logic eo);
    int n = 0;
    while (!ifb.in_ready && n < 50) begin step(); n++; end
    ifb.in_valid = 1'b1;
    ifb.bin      = b;
    ifb.mode     = m;
    step();
    ifb.in_valid = 1'b0;
    n = 0;
    while (!ifb.out_valid && n < 50) begin step(); n++; end
    chk({tag, " out_valid"}, 32'(ifb.out_valid), 32'd1);
    chk({tag, " digits"}, 32'(ifb.digits), 32'(ed));
    chk({tag, " ovf"}, 32'(ifb.overflow), 32'(eo));
    step();
  endtask

  initial begin
    int n;
    int seen;
    int acc0;
    int out0;
    rst_n = 1'b0;
    ifa.in_valid = 1'b0; ifa.bin = '0; ifa.mode = 1'b0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.bin = '0; ifb.mode = 1'b0; ifb.out_ready = 1'b1;
    repeat (3) step();
    chk("in_ready in reset", 32'(ifa.in_ready), 32'd0);
    rst_n = 1'b1;
    step();
    chk("reset in_ready", 32'(ifa.in_ready), 32'd1);
    chk("reset out_valid", 32'(ifa.out_valid), 32'd0);
    chk("reset digits", 32'(ifa.digits), 32'd0);
    chk("reset ovf", 32'(ifa.overflow), 32'd0);

    run_a("bcd255", 8'd255, 1'b0, 12'h255, 1'b0);
    run_a("xs3_255", 8'd255, 1'b1, 12'h588, 1'b0);
    run_a("xs3_0", 8'd0, 1'b1, 12'h333, 1'b0);
    run_a("xs3_9", 8'd9, 1'b1, 12'h33C, 1'b0);
    run_a("bcd_0", 8'd0, 1'b0, 12'h000, 1'b0);

    run_b("d2_100", 8'd100, 1'b0, 8'h00, 1'b1);
    run_b("d2_99", 8'd99, 1'b0, 8'h99, 1'b0);
    run_b("d2_213", 8'd213, 1'b0, 8'h13, 1'b1);
    run_b("d2_xs3_213", 8'd213, 1'b1, 8'h46, 1'b1);

    ifa.out_ready = 1'b0;
    accept_a("bp", 8'd123, 1'b0);
    n = 0;
    while (!ifa.out_valid && n < 50) begin step(); n++; end
    for (int i = 0; i < 5; i++) begin
      ifa.in_valid = 1'b1;
      ifa.bin      = 8'd7;
      ifa.mode     = 1'b0;
      chk("bp out_valid", 32'(ifa.out_valid), 32'd1);
      chk("bp digits", 32'(ifa.digits), 32'h123);
      chk("bp in_ready", 32'(ifa.in_ready), 32'd0);
      step();
    end
    ifa.in_valid  = 1'b0;
    ifa.out_ready = 1'b1;
    step();
    chk("bp handoff out_valid", 32'(ifa.out_valid), 32'd0);
    chk("bp handoff in_ready", 32'(ifa.in_ready), 32'd1);
    run_a("after_bp", 8'd7, 1'b0, 12'h007, 1'b0);

    accept_a("rst_mid", 8'd200, 1'b0);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("rst_mid in_ready low", 32'(ifa.in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_mid out_valid", 32'(ifa.out_valid), 32'd0);
    chk("rst_mid digits", 32'(ifa.digits), 32'd0);
    chk("rst_mid in_ready", 32'(ifa.in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (ifa.out_valid) seen++;
      step();
    end
    chk("rst_mid no output", 32'(seen), 32'd0);
    run_a("xs3_42", 8'd42, 1'b1, 12'h375, 1'b0);

    acc0 = n_acc;
    out0 = n_out;
    for (int m = 0; m < 2; m++) begin
      for (int v = 0; v < 256; v++) begin
        accept_a("sweep", 8'(v), 1'(m));
        n = 0;
        while (n < 200) begin
          ifa.out_ready = 1'($urandom_range(0, 1));
          #1;
          if (ifa.out_valid && ifa.out_ready) begin
            chk("sweep digits", 32'(ifa.digits), 32'(ref_a(v, 1'(m))));
            chk("sweep ovf", 32'(ifa.overflow), 32'd0);
            step();
            break;
          end
          step();
          n++;
        end
        if (n >= 200) chk("sweep timeout", 32'(n), 32'd0);
      end
    end
    ifa.out_ready = 1'b1;
    step();
    chk("sweep accepts", 32'(n_acc - acc0), 32'd512);
    chk("sweep outputs", 32'(n_out - out0), 32'd512);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
